// File: rtl/morse_key_sequencer_if.sv
// rtl/morse_key_sequencer_if.sv - letter request/handshake and key output bundle for the Morse sequencer
interface morse_key_sequencer_if;
    logic       req;
    logic [3:0] pattern;
    logic [2:0] length;
    logic       abort;
    logic       key_out;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output req, pattern, length, abort,
        input  key_out, busy, done, err
    );

    modport slave (
        input  req, pattern, length, abort,
        output key_out, busy, done, err
    );
endinterface

// File: rtl/morse_key_sequencer.sv
// rtl/morse_key_sequencer.sv - times the marks, spaces and letter gap of one Morse letter onto a key line
module morse_key_sequencer #(
    parameter int UNIT_CYCLES = 25_000_000,
    parameter int DASH_UNITS  = 3,
    parameter int GAP_UNITS   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    morse_key_sequencer_if.slave  bus
);
    localparam int MAX_UNITS = (DASH_UNITS > GAP_UNITS) ? DASH_UNITS : GAP_UNITS;
    localparam int CNT_W     = $clog2(MAX_UNITS * UNIT_CYCLES + 1);

    localparam logic [CNT_W-1:0] DOT_LAST  = CNT_W'(UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DASH_LAST = CNT_W'(DASH_UNITS * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_UNITS * UNIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       sreg, sreg_n;
    logic [2:0]       elems, elems_n;
    logic             err_q, err_n;
    logic             legal;
    logic [CNT_W-1:0] mark_last;

    assign legal     = (bus.length != 3'd0) && (bus.length <= 3'd4);
    assign mark_last = sreg[0] ? DASH_LAST : DOT_LAST;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            sreg  <= '0;
            elems <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            sreg  <= sreg_n;
            elems <= elems_n;
            err_q <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + CNT_W'(1);
        sreg_n  = sreg;
        elems_n = elems;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (bus.req) begin
                    if (legal) begin
                        sreg_n  = bus.pattern;
                        elems_n = bus.length;
                        state_n = MARK;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            MARK: begin
                if (cnt == mark_last) begin
                    cnt_n   = '0;
                    elems_n = elems - 3'd1;
                    // The letter gap absorbs the final inter-element space.
                    if (elems > 3'd1) begin
                        state_n = SPACE;
                        sreg_n  = {1'b0, sreg[3:1]};
                    end else begin
                        state_n = GAP;
                    end
                end
            end
            SPACE: begin
                if (cnt == DOT_LAST) begin
                    cnt_n   = '0;
                    state_n = MARK;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
        if (bus.abort && (state != IDLE)) begin
            state_n = IDLE;
            cnt_n   = '0;
        end
    end

    // Outputs decode the registered state so async reset drops the key at once.
    assign bus.key_out = (state == MARK);
    assign bus.busy    = (state != IDLE);
    assign bus.done    = (state == GAP) && (cnt == GAP_LAST);
    assign bus.err     = err_q;
endmodule

// File: tb/tb_morse_key_sequencer.sv
// tb/tb_morse_key_sequencer.sv - scoreboard bench for morse_key_sequencer output transitions
module tb_morse_key_sequencer;
    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;

    typedef struct {
        int         cyc;
        logic [3:0] v;
    } ev_t;

    ev_t        expq[$];
    logic [3:0] prev;

    morse_key_sequencer_if kif ();

    morse_key_sequencer #(
        .UNIT_CYCLES (4),
        .DASH_UNITS  (3),
        .GAP_UNITS   (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (kif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Every change of {key_out, busy, done, err} must match the next expected snapshot.
    always @(negedge clk) begin
        logic [3:0] cur;
        ev_t        e;
        cur = {kif.key_out, kif.busy, kif.done, kif.err};
        if (cur !== prev) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change cycle %0d got %b required no change", cyc, cur);
            end else begin
                e = expq.pop_front();
                if (e.cyc != cyc || e.v !== cur) begin
                    errors++;
                    $display("FAIL transition cycle %0d got %b required cycle %0d value %b",
                             cyc, cur, e.cyc, e.v);
                end
            end
            prev = cur;
        end
    end

    task automatic push(input int c, input logic [3:0] v);
        ev_t e;
        e.cyc = c;
        e.v   = v;
        expq.push_back(e);
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start(input logic [3:0] p, input logic [2:0] l, output int b);
        @(posedge clk);
        #1;
        kif.req     = 1'b1;
        kif.pattern = p;
        kif.length  = l;
        b = cyc;
    endtask

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %b required %b", name, got, want);
        end
    endtask

    // Expected {key,busy,done,err} transitions for letter E started at b.
    task automatic push_e(input int b);
        push(b + 1,  4'b1100);
        push(b + 5,  4'b0100);
        push(b + 16, 4'b0110);
        push(b + 17, 4'b0000);
    endtask

    task automatic push_a(input int b);
        push(b + 1,  4'b1100);
        push(b + 5,  4'b0100);
        push(b + 9,  4'b1100);
        push(b + 21, 4'b0100);
        push(b + 32, 4'b0110);
        push(b + 33, 4'b0000);
    endtask

    initial begin
        int b;
        checks      = 0;
        errors      = 0;
        prev        = 4'b0000;
        reset       = 1'b1;
        kif.req     = 1'b0;
        kif.pattern = 4'b0000;
        kif.length  = 3'd0;
        kif.abort   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {kif.key_out, kif.busy, kif.done, kif.err}, 4'b0000);
        reset = 1'b0;
        // abort while idle has no effect
        kif.abort = 1'b1;
        @(posedge clk);
        #1;
        kif.abort = 1'b0;

        // E, with pattern/length disturbed while busy
        start(4'b0000, 3'd1, b);
        push_e(b);
        goto(b + 1);
        kif.req     = 1'b0;
        kif.pattern = 4'b1111;
        kif.length  = 3'd7;
        goto(b + 20);

        // A: dot, space, dash, gap
        start(4'b0010, 3'd2, b);
        push_a(b);
        goto(b + 1);
        kif.req     = 1'b0;
        kif.pattern = 4'b1111;
        goto(b + 36);

        // req held high: A then T latched in first idle cycle
        start(4'b0010, 3'd2, b);
        push_a(b);
        push(b + 34, 4'b1100);
        push(b + 46, 4'b0100);
        push(b + 57, 4'b0110);
        push(b + 58, 4'b0000);
        goto(b + 1);
        kif.pattern = 4'b0001;
        kif.length  = 3'd1;
        goto(b + 40);
        kif.req = 1'b0;
        goto(b + 62);

        // illegal length
        start(4'b0000, 3'd5, b);
        push(b + 1, 4'b0001);
        push(b + 2, 4'b0000);
        goto(b + 1);
        kif.req    = 1'b0;
        kif.length = 3'd1;
        goto(b + 6);

        // H aborted during first space, then E accepted normally
        start(4'b0000, 3'd4, b);
        push(b + 1, 4'b1100);
        push(b + 5, 4'b0100);
        push(b + 7, 4'b0000);
        goto(b + 1);
        kif.req = 1'b0;
        goto(b + 6);
        kif.abort = 1'b1;
        goto(b + 7);
        kif.abort = 1'b0;
        goto(b + 10);
        start(4'b0000, 3'd1, b);
        push_e(b);
        goto(b + 1);
        kif.req = 1'b0;
        goto(b + 20);

        // reset mid-dash of T, then E with unchanged timing
        start(4'b0001, 3'd1, b);
        push(b + 1, 4'b1100);
        push(b + 6, 4'b0000);
        goto(b + 1);
        kif.req = 1'b0;
        goto(b + 6);
        reset = 1'b1;
        #1;
        check("async_reset_key", {3'b000, kif.key_out}, 4'b0000);
        goto(b + 8);
        reset = 1'b0;
        start(4'b0000, 3'd1, b);
        push_e(b);
        goto(b + 1);
        kif.req = 1'b0;
        goto(b + 25);

        check("pending_expected", 4'(expq.size()), 4'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
